// File: rtl/sram_arb.sv
// rtl/sram_arb.sv - single-port SRAM arbiter: video reads first, buffered host writes drained in blanking
//
// Purpose: shares one asynchronous SRAM between the video fetch (read, highest
// priority) and a host write port. Host writes are queued in a FIFO and each is
// replayed as a three-cycle SETUP/STROBE/HOLD sequence, only while wr_win is high.
//
// Optional feature macro: SRAM_ARB_COLLIDE_EN (sticky collision flag on coll).
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   v_req, v_addr              video read request and {y,x} address
//   wr_win                     write window from the timing generator
//   wr_valid, wr_ready         host write handshake
//   wr_addr, wr_data, wr_be    host write address, data, byte enables
//   wr_busy                    FIFO non-empty or write sequence in progress
//   coll, coll_clr             sticky collision flag and its clear
//   sram_dq_i                  SRAM read data (consumed by the video stage)
//   sram_dq_o, sram_dq_oe      SRAM write data and its tristate enable
//   sram_addr                  registered SRAM address
//   sram_oe_n, sram_we_n,
//   sram_lb_n, sram_ub_n       registered SRAM strobes
module sram_arb #(
  parameter int FIFO_AW = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        v_req,
  input  logic [17:0] v_addr,
  input  logic        wr_win,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [17:0] wr_addr,
  input  logic [15:0] wr_data,
  input  logic [1:0]  wr_be,
  output logic        wr_busy,
  output logic        coll,
  input  logic        coll_clr,
  input  logic [15:0] sram_dq_i,
  output logic [15:0] sram_dq_o,
  output logic        sram_dq_oe,
  output logic [17:0] sram_addr,
  output logic        sram_oe_n,
  output logic        sram_we_n,
  output logic        sram_lb_n,
  output logic        sram_ub_n
);

  localparam int DEPTH = 1 << FIFO_AW;

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;
  state_t state;

  // FIFO entry layout: {be[35:34], addr[33:16], data[15:0]}
  logic [35:0]        mem [DEPTH];
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW:0]   count;
  logic [35:0]        head;
  logic [1:0]         be_q;
  logic               empty;
  logic               push;
  logic               pop;
  logic               unused_in;

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  // count never exceeds DEPTH, so its MSB alone marks "full".
  assign wr_ready = ~count[FIFO_AW];
  assign push     = wr_valid & wr_ready;
  // A new write may only start from IDLE or straight out of HOLD, and never
  // while video is asking for the bus.
  assign pop      = ((state == IDLE) || (state == HOLD)) & ~v_req & wr_win & ~empty;
  assign wr_busy  = ~empty | (state != IDLE);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {wr_be, wr_addr, wr_data};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (FIFO_AW)'(1);
      if (pop)  rd_ptr <= rd_ptr + (FIFO_AW)'(1);
      case ({push, pop})
        2'b10:   count <= count + (FIFO_AW+1)'(1);
        2'b01:   count <= count - (FIFO_AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      sram_addr  <= '0;
      sram_dq_o  <= '0;
      sram_dq_oe <= 1'b0;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      sram_lb_n  <= 1'b1;
      sram_ub_n  <= 1'b1;
      be_q       <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (v_req) begin
            sram_addr  <= v_addr;
            sram_oe_n  <= 1'b0;
            sram_we_n  <= 1'b1;
            sram_lb_n  <= 1'b0;
            sram_ub_n  <= 1'b0;
            sram_dq_oe <= 1'b0;
          end else if (pop) begin
            state      <= SETUP;
            sram_addr  <= head[33:16];
            sram_dq_o  <= head[15:0];
            be_q       <= head[35:34];
            sram_dq_oe <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_we_n  <= 1'b1;
            sram_lb_n  <= 1'b1;
            sram_ub_n  <= 1'b1;
          end else begin
            sram_dq_oe <= 1'b0;
            sram_oe_n  <= 1'b1;
            sram_we_n  <= 1'b1;
            sram_lb_n  <= 1'b1;
            sram_ub_n  <= 1'b1;
          end
        end
        SETUP: begin
          state     <= STROBE;
          sram_we_n <= 1'b0;
          sram_lb_n <= ~be_q[0];
          sram_ub_n <= ~be_q[1];
        end
        STROBE: begin
          state     <= HOLD;
          sram_we_n <= 1'b1;
          sram_lb_n <= 1'b1;
          sram_ub_n <= 1'b1;
        end
        HOLD: begin
          if (pop) begin
            // Chain straight into the next write; the bus stays driven.
            state      <= SETUP;
            sram_addr  <= head[33:16];
            sram_dq_o  <= head[15:0];
            be_q       <= head[35:34];
            sram_dq_oe <= 1'b1;
          end else begin
            state      <= IDLE;
            sram_dq_oe <= 1'b0;
          end
          sram_oe_n <= 1'b1;
          sram_we_n <= 1'b1;
          sram_lb_n <= 1'b1;
          sram_ub_n <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SRAM_ARB_COLLIDE_EN
  // Video asked for the bus while a write sequence owned it.
  always_ff @(posedge clk) begin
    if (!rst_n)                        coll <= 1'b0;
    else if (coll_clr)                 coll <= 1'b0;
    else if (v_req && state != IDLE)   coll <= 1'b1;
  end
  assign unused_in = ^sram_dq_i;
`else
  assign coll      = 1'b0;
  assign unused_in = ^{sram_dq_i, coll_clr};
`endif

endmodule

// File: tb/tb_sram_arb.sv
// tb/tb_sram_arb.sv - self-checking bench for sram_arb
module tb_sram_arb;

  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        v_req;
  logic [17:0] v_addr;
  logic        wr_win;
  logic        wr_valid;
  logic        wr_ready;
  logic [17:0] wr_addr;
  logic [15:0] wr_data;
  logic [1:0]  wr_be;
  logic        wr_busy;
  logic        coll;
  logic        coll_clr;
  logic [15:0] sram_dq_i;
  logic [15:0] sram_dq_o;
  logic        sram_dq_oe;
  logic [17:0] sram_addr;
  logic        sram_oe_n;
  logic        sram_we_n;
  logic        sram_lb_n;
  logic        sram_ub_n;

  always #5 clk = ~clk;

  sram_arb #(.FIFO_AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .v_req(v_req), .v_addr(v_addr), .wr_win(wr_win),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .wr_busy(wr_busy), .coll(coll), .coll_clr(coll_clr),
    .sram_dq_i(sram_dq_i), .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe),
    .sram_addr(sram_addr), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
    .sram_lb_n(sram_lb_n), .sram_ub_n(sram_ub_n)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [1:0]  be;
    logic [17:0] addr;
    logic [15:0] data;
  } ent_t;

  ent_t        q[$];
  ent_t        cur;
  int          phase = 0;   // 0 bus free, 1..3 = cycle of the write sequence
  bit          mvalid = 0;
  logic [17:0] m_addr;
  logic [15:0] m_dq;
  logic        m_dq_oe, m_oe, m_we, m_lb, m_ub, m_coll;

  task automatic m_idle();
    m_dq_oe = 1'b0; m_oe = 1'b1; m_we = 1'b1; m_lb = 1'b1; m_ub = 1'b1;
  endtask

  task automatic m_start();
    cur = q.pop_front();
    m_addr = cur.addr; m_dq = cur.data; m_dq_oe = 1'b1;
    m_oe = 1'b1; m_we = 1'b1; m_lb = 1'b1; m_ub = 1'b1;
    phase = 1;
  endtask

  always @(posedge clk) begin : model
    bit do_push;
    if (!rst_n) begin
      q.delete();
      phase = 0; m_addr = '0; m_dq = '0; m_coll = 1'b0;
      m_idle();
      mvalid = 1;
    end else begin
      do_push = wr_valid && (q.size() < DEPTH);
`ifdef SRAM_ARB_COLLIDE_EN
      if (coll_clr) m_coll = 1'b0;
      else if (v_req && phase != 0) m_coll = 1'b1;
`else
      m_coll = 1'b0;
`endif
      case (phase)
        0: begin
          if (v_req) begin
            m_addr = v_addr; m_oe = 1'b0; m_we = 1'b1; m_lb = 1'b0; m_ub = 1'b0; m_dq_oe = 1'b0;
          end else if (q.size() > 0 && wr_win) m_start();
          else m_idle();
        end
        1: begin m_we = 1'b0; m_lb = ~cur.be[0]; m_ub = ~cur.be[1]; phase = 2; end
        2: begin m_we = 1'b1; m_lb = 1'b1; m_ub = 1'b1; phase = 3; end
        default: begin
          if (q.size() > 0 && wr_win && !v_req) m_start();
          else begin m_idle(); phase = 0; end
        end
      endcase
      if (do_push) q.push_back({wr_be, wr_addr, wr_data});
    end
  end

  // ---------------- compare + monitor ----------------
  int          cyc = 0;
  int          npulse, oe_cyc, strobe_low, last_cyc, min_gap, max_gap;
  logic [15:0] pdata [32];
  logic [17:0] paddr [32];
  logic        plb [32];
  logic        pub [32];

  task automatic mon_clear();
    npulse = 0; oe_cyc = 0; strobe_low = 0; last_cyc = 0; min_gap = 1000; max_gap = 0;
  endtask

  always @(negedge clk) begin
    cyc++;
    if (mvalid) begin
      check("sram_addr", sram_addr, m_addr);
      check("sram_dq_o", sram_dq_o, m_dq);
      check("sram_dq_oe", sram_dq_oe, m_dq_oe);
      check("sram_oe_n", sram_oe_n, m_oe);
      check("sram_we_n", sram_we_n, m_we);
      check("sram_lb_n", sram_lb_n, m_lb);
      check("sram_ub_n", sram_ub_n, m_ub);
      check("wr_ready", wr_ready, (q.size() < DEPTH));
      check("wr_busy", wr_busy, (q.size() > 0 || phase != 0));
      check("coll", coll, m_coll);
      if (sram_oe_n === 1'b0) check("no_contention", sram_dq_oe, 1'b0);
    end
    if (sram_we_n === 1'b0) begin
      if (npulse > 0) begin
        if (cyc - last_cyc < min_gap) min_gap = cyc - last_cyc;
        if (cyc - last_cyc > max_gap) max_gap = cyc - last_cyc;
      end
      if (npulse < 32) begin
        pdata[npulse] = sram_dq_o; paddr[npulse] = sram_addr;
        plb[npulse] = sram_lb_n; pub[npulse] = sram_ub_n;
      end
      npulse++;
      last_cyc = cyc;
    end
    if (sram_dq_oe === 1'b1) oe_cyc++;
    if (sram_oe_n === 1'b1 && (sram_lb_n === 1'b0 || sram_ub_n === 1'b0)) strobe_low++;
  end

  // ---------------- directed stimulus ----------------
  task automatic tick(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic push(input logic [17:0] a, input logic [15:0] d, input logic [1:0] be);
    wr_valid = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
    tick(1);
    wr_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; v_req = 1'b0; v_addr = '0; wr_win = 1'b0; wr_valid = 1'b1;
    wr_addr = '0; wr_data = '0; wr_be = 2'b11; coll_clr = 1'b0; sram_dq_i = 16'h0;
    mon_clear();

    // Reset held two cycles with wr_valid high
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check("rst_we_n", sram_we_n, 1'b1);
    check("rst_oe_n", sram_oe_n, 1'b1);
    check("rst_lb_ub", {sram_lb_n, sram_ub_n}, 2'b11);
    check("rst_dq_oe", sram_dq_oe, 1'b0);
    check("rst_wr_ready", wr_ready, 1'b1);
    check("rst_wr_busy", wr_busy, 1'b0);
    wr_valid = 1'b0; rst_n = 1'b1;
    tick(2);

    // Single write
    wr_win = 1'b1; mon_clear();
    push(18'h00A05, 16'h7C1F, 2'b11);
    tick(8);
    check("single_pulses", npulse, 1);
    check("single_addr", paddr[0], 18'h00A05);
    check("single_data", pdata[0], 16'h7C1F);
    check("single_lb_ub", {plb[0], pub[0]}, 2'b00);
    check("single_dq_oe_cycles", oe_cyc, 3);
    check("single_busy_done", wr_busy, 1'b0);

    // Fill 20 with window closed, then drain
    wr_win = 1'b0; mon_clear();
    for (int i = 0; i < 20; i++) begin
      wr_valid = 1'b1; wr_addr = 18'(i); wr_data = 16'h1000 + 16'(i); wr_be = 2'b11;
      tick(1);
    end
    wr_valid = 1'b0;
    check("fill_ready_low", wr_ready, 1'b0);
    check("fill_busy", wr_busy, 1'b1);
    wr_win = 1'b1;
    tick(60);
    check("drain_pulses", npulse, 16);
    check("drain_min_gap", min_gap, 3);
    check("drain_max_gap", max_gap, 3);
    for (int k = 0; k < 16; k++) check("drain_order", pdata[k], 16'h1000 + 16'(k));
    check("drain_idle", wr_busy, 1'b0);

    // Video priority over a pending write
    wr_win = 1'b0;
    push(18'h00123, 16'h0ABC, 2'b11);
    tick(2);
    mon_clear();
    v_req = 1'b1; v_addr = 18'h3FFFF; wr_win = 1'b1;
    tick(1);
    check("vid_addr", sram_addr, 18'h3FFFF);
    check("vid_oe_n", sram_oe_n, 1'b0);
    tick(4);
    check("vid_no_setup", oe_cyc, 0);
    check("vid_no_write", npulse, 0);
    v_req = 1'b0;
    tick(6);
    check("vid_after_pulses", npulse, 1);
    check("vid_after_data", pdata[0], 16'h0ABC);

    // Byte enables
    mon_clear();
    push(18'h00200, 16'h1234, 2'b10);
    tick(6);
    check("be10_pulses", npulse, 1);
    check("be10_lb_ub", {plb[0], pub[0]}, 2'b10);
    mon_clear();
    push(18'h00201, 16'h4321, 2'b00);
    tick(6);
    check("be00_pulses", npulse, 1);
    check("be00_no_strobe", strobe_low, 0);
    check("be00_dq_oe_cycles", oe_cyc, 3);

    // Collision: video request arrives during STROBE
    mon_clear();
    push(18'h00300, 16'h5555, 2'b11);
    for (int k = 0; k < 20 && sram_we_n !== 1'b0; k++) tick(1);
    check("coll_reach_strobe", sram_we_n, 1'b0);
    v_req = 1'b1; v_addr = 18'h12345;
    tick(1);
`ifdef SRAM_ARB_COLLIDE_EN
    check("coll_set", coll, 1'b1);
`else
    check("coll_off", coll, 1'b0);
`endif
    tick(2);
    check("coll_read_addr", sram_addr, 18'h12345);
    check("coll_read_oe_n", sram_oe_n, 1'b0);
    check("coll_write_done", npulse, 1);
    check("coll_write_data", pdata[0], 16'h5555);
    v_req = 1'b0; coll_clr = 1'b1;
    tick(1);
    coll_clr = 1'b0;
    check("coll_cleared", coll, 1'b0);
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
